// File: rtl/hazard_unit_pkg.sv
// Shared definitions for the hazard unit: forwarding selects, divider FSM states
// and the default register-number width.
package cpu_defs;

    localparam int unsigned REG_AW = 5;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline-side view of the hazard unit: stage register numbers and flags in,
// stalls, flushes, forwarding selects and divider handshake out.
interface hazard_if #(
    parameter int unsigned REG_AW = cpu_defs::REG_AW
);
    logic [REG_AW-1:0] rsD, rtD;
    logic              branchD, jrD, jalrD;
    logic [REG_AW-1:0] rsE, rtE, writeregE;
    logic              regwriteE, memtoregE;
    logic [REG_AW-1:0] writeregM;
    logic              regwriteM, memtoregM;
    logic [REG_AW-1:0] writeregW;
    logic              regwriteW;
    logic              div_reqE, div_done, except_validM;

    logic              div_start, div_abort;
    logic              stallF, stallD, stallE;
    logic              flushD, flushE, flushM, flushW;
    logic              forwardAD, forwardBD;
    logic [1:0]        forwardAE, forwardBE;

    modport master (
        output rsD, rtD, branchD, jrD, jalrD, rsE, rtE, writeregE, regwriteE, memtoregE,
               writeregM, regwriteM, memtoregM, writeregW, regwriteW,
               div_reqE, div_done, except_validM,
        input  div_start, div_abort, stallF, stallD, stallE,
               flushD, flushE, flushM, flushW, forwardAD, forwardBD, forwardAE, forwardBE
    );

    modport slave (
        input  rsD, rtD, branchD, jrD, jalrD, rsE, rtE, writeregE, regwriteE, memtoregE,
               writeregM, regwriteM, memtoregM, writeregW, regwriteW,
               div_reqE, div_done, except_validM,
        output div_start, div_abort, stallF, stallD, stallE,
               flushD, flushE, flushM, flushW, forwardAD, forwardBD, forwardAE, forwardBE
    );
endinterface

// File: rtl/hazard_unit_div_handshake.sv
// Launch/abort handshake with the multi-cycle divider in E; holds the pipeline
// while a divide is outstanding.
module div_handshake
    import cpu_defs::*;
(
    input  logic clk,
    input  logic resetn,
    input  logic div_req_i,
    input  logic div_done_i,
    input  logic except_valid_i,
    output logic div_start_o,
    output logic div_abort_o,
    output logic div_stall_o
);

    div_state_t state_q, state_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        div_start_o = 1'b0;
        div_abort_o = 1'b0;
        div_stall_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                div_stall_o = div_req_i;
                if (div_req_i && !except_valid_i) begin
                    div_start_o = 1'b1;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                div_stall_o = !div_done_i;
                // An exception beats a completing divide; its result is dropped.
                if (except_valid_i) begin
                    div_abort_o = 1'b1;
                    state_d     = IDLE;
                end else if (div_done_i) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // The departing divide is still in E here, so no relaunch.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/hazard_unit.sv
// Stall, flush and forwarding generation for the 5-stage pipeline, with the
// divider handshake as a sub-block.
module hazard_unit
    import cpu_defs::*;
#(
    parameter int unsigned REG_AW = cpu_defs::REG_AW
) (
    input logic     clk,
    input logic     resetn,
    hazard_if.slave hz
);

    logic div_stall, lwstall, brstall, branch_like;

    // Register 0 is hard-wired, so it never creates a dependency.
    function automatic logic reg_match(logic [REG_AW-1:0] a, logic [REG_AW-1:0] b);
        return (a != '0) && (a == b);
    endfunction

    div_handshake u_div_handshake (
        .clk            (clk),
        .resetn         (resetn),
        .div_req_i      (hz.div_reqE),
        .div_done_i     (hz.div_done),
        .except_valid_i (hz.except_validM),
        .div_start_o    (hz.div_start),
        .div_abort_o    (hz.div_abort),
        .div_stall_o    (div_stall)
    );

    always_comb begin
        hz.forwardAE = FWD_RF;
        if (hz.regwriteM && reg_match(hz.writeregM, hz.rsE)) begin
            hz.forwardAE = FWD_M;
        end else if (hz.regwriteW && reg_match(hz.writeregW, hz.rsE)) begin
            hz.forwardAE = FWD_W;
        end
        hz.forwardBE = FWD_RF;
        if (hz.regwriteM && reg_match(hz.writeregM, hz.rtE)) begin
            hz.forwardBE = FWD_M;
        end else if (hz.regwriteW && reg_match(hz.writeregW, hz.rtE)) begin
            hz.forwardBE = FWD_W;
        end
        hz.forwardAD = hz.regwriteM && reg_match(hz.writeregM, hz.rsD);
        hz.forwardBD = hz.regwriteM && reg_match(hz.writeregM, hz.rtD);
    end

    assign branch_like = hz.branchD || hz.jrD || hz.jalrD;
    assign lwstall = hz.memtoregE &&
                     (reg_match(hz.writeregE, hz.rsD) || reg_match(hz.writeregE, hz.rtD));
    assign brstall = branch_like &&
        ((hz.regwriteE && (reg_match(hz.writeregE, hz.rsD) ||
                           reg_match(hz.writeregE, hz.rtD))) ||
         (hz.memtoregM && (reg_match(hz.writeregM, hz.rsD) ||
                           reg_match(hz.writeregM, hz.rtD))));

    always_comb begin
        hz.stallF = 1'b0;
        hz.stallD = 1'b0;
        hz.stallE = 1'b0;
        hz.flushD = 1'b0;
        hz.flushE = 1'b0;
        hz.flushM = 1'b0;
        hz.flushW = 1'b0;
        if (hz.except_validM) begin
            hz.flushD = 1'b1;
            hz.flushE = 1'b1;
            hz.flushM = 1'b1;
            hz.flushW = 1'b1;
        end else if (div_stall) begin
            // E is frozen on the divide, so M receives a bubble each cycle.
            hz.stallF = 1'b1;
            hz.stallD = 1'b1;
            hz.stallE = 1'b1;
            hz.flushM = 1'b1;
        end else if (lwstall || brstall) begin
            hz.stallF = 1'b1;
            hz.stallD = 1'b1;
            hz.flushE = 1'b1;
        end
    end

endmodule
